// File: rtl/qvga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qvga_pkg
// Brief    : Shared types and defaults for the QVGA frame-buffer write path.
// Revision : 1.0 - initial release
// ============================================================================
package qvga_pkg;

   localparam int H_PIX_DEF   = 320;
   localparam int V_LINES_DEF = 240;
   localparam int SYNC_FF_DEF = 2;
   localparam int FB_DEPTH    = H_PIX_DEF * V_LINES_DEF;

   // One 12-bit frame-buffer pixel, stored as {R,G,B}
   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_VS = 2'd1,
      CAPTURE = 2'd2
   } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/qvga_frame_writer_cam_in_sync.sv
`default_nettype none
// ============================================================================
// Module   : cam_in_sync
// Brief    : Synchronizes all camera pins through one shared flop chain so
//            they stay mutually aligned, then derives pclk/vsync/href edges.
// Revision : 1.0 - initial release
// ============================================================================
module cam_in_sync
   import qvga_pkg::*;
#(
   parameter int SYNC_FF = SYNC_FF_DEF
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       pclk_i,
   input  logic       vsync_i,
   input  logic       href_i,
   input  logic [7:0] data_i,
   output logic       pclk_rise_o,
   output logic       vs_rise_o,
   output logic       vs_fall_o,
   output logic       href_o,
   output logic       href_fall_o,
   output logic [7:0] data_o
);

   localparam int W = 11;

   logic [SYNC_FF-1:0][W-1:0] chain_q;
   logic [W-1:0]              w_sync;
   logic                      pclk_prev_q;
   logic                      vs_prev_q;
   logic                      href_prev_q;
   logic                      w_pclk;
   logic                      w_vs;
   logic                      w_href;

   // Shift all pins through the same number of stages
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         chain_q <= '0;
      end else begin
         chain_q[0] <= {pclk_i, vsync_i, href_i, data_i};
         for (int i = 1; i < SYNC_FF; i++) begin
            chain_q[i] <= chain_q[i-1];
         end
      end
   end

   assign w_sync = chain_q[SYNC_FF-1];
   assign w_pclk = w_sync[10];
   assign w_vs   = w_sync[9];
   assign w_href = w_sync[8];

   // Previous synchronized level of each control pin for edge detection
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pclk_prev_q <= 1'b0;
         vs_prev_q   <= 1'b0;
         href_prev_q <= 1'b0;
      end else begin
         pclk_prev_q <= w_pclk;
         vs_prev_q   <= w_vs;
         href_prev_q <= w_href;
      end
   end

   assign pclk_rise_o = w_pclk & ~pclk_prev_q;
   assign vs_rise_o   = w_vs & ~vs_prev_q;
   assign vs_fall_o   = ~w_vs & vs_prev_q;
   assign href_o      = w_href;
   assign href_fall_o = ~w_href & href_prev_q;
   assign data_o      = w_sync[7:0];

endmodule
`default_nettype wire

// File: rtl/qvga_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : qvga_frame_writer
// Brief    : Captures an RGB444 camera stream and issues one 12-bit write per
//            pixel at linear address y*H_PIX+x into the frame buffer.
// Revision : 1.0 - initial release
// ============================================================================
module qvga_frame_writer
   import qvga_pkg::*;
#(
   parameter int H_PIX   = H_PIX_DEF,
   parameter int V_LINES = V_LINES_DEF,
   parameter int ADDR_W  = $clog2(FB_DEPTH),
   parameter int SYNC_FF = SYNC_FF_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cap_en,
   input  logic              cam_pclk,
   input  logic              cam_vsync,
   input  logic              cam_href,
   input  logic [7:0]        cam_data,
   output logic              wclk,
   output logic              we,
   output logic [ADDR_W-1:0] wAddr,
   output logic [11:0]       wData,
   output logic              frame_done,
   output logic              frame_err,
   output logic              busy
);

   localparam int X_W = $clog2(H_PIX + 1);
   localparam int Y_W = $clog2(V_LINES + 1);

   logic             w_pclk_rise;
   logic             w_vs_rise;
   logic             w_vs_fall;
   logic             w_href;
   logic             w_href_fall;
   logic [7:0]       w_data;

   cap_state_t       state_q,      state_d;
   logic [X_W-1:0]   x_q,          x_d;
   logic [Y_W-1:0]   y_q,          y_d;
   logic             phase_q,      phase_d;
   logic [3:0]       r_q,          r_d;
   logic             pend_q,       pend_d;
   logic [X_W-1:0]   pix_x_q,      pix_x_d;
   logic [Y_W-1:0]   pix_y_q,      pix_y_d;
   rgb444_t          pix_q,        pix_d;
   logic             frame_done_q, frame_done_d;
   logic             frame_err_q,  frame_err_d;

   logic             we_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [11:0]      wdata_q;
   logic [ADDR_W-1:0] w_addr;

   logic             w_line_inc;
   logic [Y_W-1:0]   w_y_plus;
   logic [Y_W-1:0]   w_y_final;

   cam_in_sync #(
      .SYNC_FF (SYNC_FF)
   ) u_sync (
      .clk_i       (clk),
      .rst_ni      (reset_n),
      .pclk_i      (cam_pclk),
      .vsync_i     (cam_vsync),
      .href_i      (cam_href),
      .data_i      (cam_data),
      .pclk_rise_o (w_pclk_rise),
      .vs_rise_o   (w_vs_rise),
      .vs_fall_o   (w_vs_fall),
      .href_o      (w_href),
      .href_fall_o (w_href_fall),
      .data_o      (w_data)
   );

   // A line only counts if it produced at least one pixel; y saturates
   assign w_line_inc = (x_q != '0) && (y_q < Y_W'(V_LINES));
   assign w_y_plus   = y_q + 1'b1;
   // Line count as it stands once a coincident href fall is accounted for
   assign w_y_final  = (w_href_fall && w_line_inc) ? w_y_plus : y_q;

   // Capture FSM state and pixel-stage registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         x_q          <= '0;
         y_q          <= '0;
         phase_q      <= 1'b0;
         r_q          <= '0;
         pend_q       <= 1'b0;
         pix_x_q      <= '0;
         pix_y_q      <= '0;
         pix_q        <= '0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         phase_q      <= phase_d;
         r_q          <= r_d;
         pend_q       <= pend_d;
         pix_x_q      <= pix_x_d;
         pix_y_q      <= pix_y_d;
         pix_q        <= pix_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // Next-state: frame start, byte pairing, line end (wins over pclk), frame end
   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      phase_d      = phase_q;
      r_d          = r_q;
      pend_d       = 1'b0;
      pix_x_d      = pix_x_q;
      pix_y_d      = pix_y_q;
      pix_d        = pix_q;
      frame_done_d = 1'b0;
      frame_err_d  = frame_err_q;
      case (state_q)
         IDLE: begin
            state_d = WAIT_VS;
         end
         WAIT_VS: begin
            if (w_vs_fall && cap_en) begin
               state_d     = CAPTURE;
               x_d         = '0;
               y_d         = '0;
               phase_d     = 1'b0;
               frame_err_d = 1'b0;
            end
         end
         CAPTURE: begin
            if (w_vs_rise) begin
               state_d      = WAIT_VS;
               frame_done_d = 1'b1;
               frame_err_d  = (w_y_final != Y_W'(V_LINES));
            end else if (w_href_fall) begin
               if (w_line_inc) begin
                  y_d = w_y_plus;
               end
               x_d     = '0;
               phase_d = 1'b0;
            end else if (w_pclk_rise && w_href) begin
               if (!phase_q) begin
                  r_d     = w_data[3:0];
                  phase_d = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  if ((x_q < X_W'(H_PIX)) && (y_q < Y_W'(V_LINES))) begin
                     pend_d  = 1'b1;
                     pix_x_d = x_q;
                     pix_y_d = y_q;
                     pix_d.r = r_q;
                     pix_d.g = w_data[7:4];
                     pix_d.b = w_data[3:0];
                  end
                  if (x_q < X_W'(H_PIX)) begin
                     x_d = x_q + 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // For the default line width the multiply reduces to two shifts and an add
   generate
      if (H_PIX == 320) begin : g_addr_shift
         assign w_addr = (ADDR_W'(pix_y_q) << 8) + (ADDR_W'(pix_y_q) << 6)
                         + ADDR_W'(pix_x_q);
      end else begin : g_addr_mul
         assign w_addr = ADDR_W'(pix_y_q) * ADDR_W'(H_PIX) + ADDR_W'(pix_x_q);
      end
   endgenerate

   // Write port: strobe for one cycle, address/data hold between writes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         we_q <= pend_q;
         if (pend_q) begin
            waddr_q <= w_addr;
            wdata_q <= pix_q;
         end
      end
   end

   assign wclk       = clk;
   assign we         = we_q;
   assign wAddr      = waddr_q;
   assign wData      = wdata_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;
   assign busy       = (state_q == CAPTURE);

endmodule
`default_nettype wire

// File: tb/tb_qvga_frame_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_qvga_frame_writer
// Brief    : Self-checking bench for qvga_frame_writer: frame table plus
//            randomized pixel data against a pixel-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qvga_frame_writer;

   localparam int H = 320;
   localparam int V = 240;

   logic        clk       = 1'b0;
   logic        reset_n   = 1'b0;
   logic        cap_en    = 1'b0;
   logic        cam_pclk  = 1'b0;
   logic        cam_vsync = 1'b0;
   logic        cam_href  = 1'b0;
   logic [7:0]  cam_data  = 8'h00;
   logic        wclk;
   logic        we;
   logic [16:0] wAddr;
   logic [11:0] wData;
   logic        frame_done;
   logic        frame_err;
   logic        busy;

   always #5 clk = ~clk;

   qvga_frame_writer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cap_en     (cap_en),
      .cam_pclk   (cam_pclk),
      .cam_vsync  (cam_vsync),
      .cam_href   (cam_href),
      .cam_data   (cam_data),
      .wclk       (wclk),
      .we         (we),
      .wAddr      (wAddr),
      .wData      (wData),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   typedef struct {
      int addr;
      int data;
   } wr_t;

   typedef struct {
      int cap_en;
      int nlines;
      int npix;
      int spec_line;
      int spec_npix;
      int spec_odd;
      int rst_line;
      int rand_npix;
      int exp_writes;
      int exp_err;
      int exp_last;
      int exp_done;
   } fvec_t;

   wr_t expq[$];
   int  total = 0;
   int  bad   = 0;
   int  writes_seen = 0;
   int  done_seen   = 0;
   int  last_addr_seen = -1;
   int  hold_addr = 0;
   int  hold_data = 0;
   bit  prev_we   = 1'b0;
   // Reference model state: current line, capture flag, sticky error, pushes
   int  ymod    = 0;
   bit  capt    = 1'b0;
   int  err_mdl = 0;
   int  pushes  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Output monitor: reset values, write ordering/content, hold behaviour
   always @(negedge clk) begin : mon
      wr_t e;
      if (!reset_n) begin
         chk("reset_outputs", {we, frame_done, frame_err, busy, wAddr, wData}, 64'd0);
         hold_addr = 0;
         hold_data = 0;
         prev_we   = 1'b0;
      end else begin
         if (we) begin
            writes_seen++;
            last_addr_seen = int'(wAddr);
            chk("we_gap", prev_we, 0);
            chk("write_expected", expq.size() > 0, 1);
            if (expq.size() > 0) begin
               e = expq.pop_front();
               chk($sformatf("wr_addr_data exp_addr=%0d", e.addr),
                   {wAddr, wData}, {e.addr[16:0], e.data[11:0]});
            end
            hold_addr = int'(wAddr);
            hold_data = int'(wData);
         end else begin
            chk("hold", {wAddr, wData}, {hold_addr[16:0], hold_data[11:0]});
         end
         if (frame_done) done_seen++;
         prev_we = we;
      end
   end

   task automatic clk_wait(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic send_byte(input logic [7:0] d);
      cam_data = d;
      cam_pclk = 1'b0;
      clk_wait(2);
      cam_pclk = 1'b1;
      clk_wait(2);
   endtask

   // Drive one line and record the writes the frame-buffer rules predict
   task automatic send_line(input int npix, input bit odd);
      logic [3:0] r;
      logic [7:0] b1;
      wr_t w;
      cam_href = 1'b1;
      for (int k = 0; k < npix; k++) begin
         r  = 4'($urandom);
         b1 = 8'($urandom);
         if (capt && k < H && ymod < V) begin
            w.addr = ymod * H + k;
            w.data = {20'd0, r, b1};
            expq.push_back(w);
            pushes++;
         end
         send_byte({4'($urandom), r});
         send_byte(b1);
      end
      if (odd) send_byte(8'($urandom));
      cam_pclk = 1'b0;
      cam_href = 1'b0;
      clk_wait(4);
      if (capt && npix > 0 && ymod < V) ymod++;
   endtask

   task automatic frame_start(input bit en);
      cap_en    = en;
      cam_vsync = 1'b1;
      clk_wait(8);
      writes_seen    = 0;
      done_seen      = 0;
      last_addr_seen = -1;
      pushes         = 0;
      ymod           = 0;
      cam_vsync      = 1'b0;
      capt           = en;
      if (capt) err_mdl = 0;
      clk_wait(8);
   endtask

   task automatic frame_end();
      clk_wait(8);
      cam_vsync = 1'b1;
      if (capt) err_mdl = (ymod != V) ? 1 : 0;
      clk_wait(12);
   endtask

   task automatic run_frame(input fvec_t v, input int idx);
      int np;
      bit odd;
      frame_start(v.cap_en != 0);
      if (capt) begin
         chk($sformatf("f%0d_start_busy", idx), busy, 1);
         chk($sformatf("f%0d_start_err_clear", idx), frame_err, 0);
      end
      for (int li = 0; li < v.nlines; li++) begin
         if (li == v.rst_line) begin
            clk_wait(8);
            reset_n = 1'b0;
            clk_wait(3);
            reset_n = 1'b1;
            capt    = 1'b0;
            err_mdl = 0;
         end
         if (v.cap_en == 0 && li == 2) cap_en = 1'b1;
         if (v.rand_npix != 0)        np = $urandom_range(3, 0);
         else if (li == v.spec_line)  np = v.spec_npix;
         else                         np = v.npix;
         odd = (li == v.spec_line) && (v.spec_odd != 0);
         send_line(np, odd);
      end
      frame_end();
      chk($sformatf("f%0d_writes_model", idx), writes_seen, pushes);
      if (v.exp_writes >= 0) chk($sformatf("f%0d_writes", idx), writes_seen, v.exp_writes);
      chk($sformatf("f%0d_queue_empty", idx), expq.size(), 0);
      chk($sformatf("f%0d_done_model", idx), done_seen, capt ? 1 : 0);
      if (v.exp_done >= 0) chk($sformatf("f%0d_done", idx), done_seen, v.exp_done);
      chk($sformatf("f%0d_err_model", idx), frame_err, err_mdl);
      if (v.exp_err >= 0) chk($sformatf("f%0d_err", idx), frame_err, v.exp_err);
      if (v.exp_last >= 0) chk($sformatf("f%0d_last_addr", idx), last_addr_seen, v.exp_last);
      chk($sformatf("f%0d_busy_end", idx), busy, 0);
   endtask

   initial begin
      fvec_t vecs[9];
      wr_t   w;
      int    lat;
      bit    found;

      //         cap lines npix sline snpix odd rst rnd  writes err last   done
      vecs[0] = '{1, 240,  1,  239,  320,  0,  -1, 0,   559,  0,  76799, 1};
      vecs[1] = '{1,   3,  4,    1,  330,  1,  -1, 0,   328,  1,    643, 1};
      vecs[2] = '{1, 100,  2,   99,  320,  0,  -1, 0,   518,  1,  31999, 1};
      vecs[3] = '{1,   2,  3,   -1,    0,  0,  -1, 0,     6,  1,    322, 1};
      vecs[4] = '{0,   5,  3,   -1,    0,  0,  -1, 0,     0,  1,     -1, 0};
      vecs[5] = '{1, 242,  1,   -1,    0,  0,  -1, 0,   240,  0,  76480, 1};
      vecs[6] = '{1, 100,  1,   -1,    0,  0,  50, 0,    50,  0,  15680, 0};
      vecs[7] = '{1,   3,  2,   -1,    0,  0,  -1, 0,     6,  1,    641, 1};
      vecs[8] = '{1, 245,  0,   -1,    0,  0,  -1, 1,    -1, -1,     -1, -1};

      // Reset held low while the camera toggles every pin
      clk_wait(2);
      cam_vsync = 1'b1;
      cam_href  = 1'b1;
      for (int i = 0; i < 6; i++) send_byte(8'(i * 37 + 5));
      cam_vsync = 1'b0;
      for (int i = 0; i < 4; i++) send_byte(8'(i * 11 + 3));
      cam_href = 1'b0;
      cam_pclk = 1'b0;
      clk_wait(4);
      reset_n = 1'b1;
      clk_wait(6);
      chk("post_reset_busy", busy, 0);
      chk("post_reset_outputs", {we, frame_done, frame_err, wAddr, wData}, 64'd0);

      // Latency probe: one pixel, measure pclk pin edge of byte 1 to we
      frame_start(1'b1);
      cam_href = 1'b1;
      w.addr = 0;
      w.data = 12'hA5C;
      expq.push_back(w);
      pushes++;
      send_byte(8'h3A);
      cam_data = 8'h5C;
      cam_pclk = 1'b0;
      clk_wait(2);
      cam_pclk = 1'b1;
      lat   = 0;
      found = 1'b0;
      for (int c = 1; c <= 10 && !found; c++) begin
         @(posedge clk);
         #1;
         if (we) begin
            lat   = c;
            found = 1'b1;
         end
      end
      #1;
      chk("latency_cycles", lat, 4);
      cam_pclk = 1'b0;
      cam_href = 1'b0;
      clk_wait(4);
      ymod = 1;
      frame_end();
      chk("probe_writes", writes_seen, 1);
      chk("probe_done", done_seen, 1);
      chk("probe_err", frame_err, 1);

      for (int i = 0; i < 9; i++) run_frame(vecs[i], i);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
